spi_controller: RTL and testbench
=================================

SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 Parameters, one per line as name, default, meaning:
- NBYTES, 4, maximum transfer length in bytes.
- NCS, 8, number of chip-select lines.

REQ-002 Ports, one per line as name, direction, width, meaning:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; one clock, synchronous, active-high (asserted = 1).
- SCOM  input  1  start command, sampled only in IDLE.
- CPOL  input  1  SPI clock polarity.
- CPHA  input  1  SPI clock phase.
- DATA_LEN  input  2  transfer length minus one (0 = 1 byte .. 3 = 4 bytes).
- CS_i  input  NCS  chip-select pattern driven during a transfer.
- TxBuffer  input  NBYTES x 8  transmit bytes; TxBuffer[NBYTES-1] is sent first.
- CIPO  input  1  serial data from peripheral.
- COPI  output  1  serial data to peripheral.
- PCLK  output  1  SPI clock.
- BUSY  output  1  high while a transfer is in progress.
- STARTING  output  1  high during the START cycle only.
- CS_gpio  output  NCS  chip-select pins.
- RxBuffer  output  NBYTES x 8  received bytes; the last received byte is in RxBuffer[0].

Function
REQ-003 The FSM SHALL have four states: IDLE -> START -> SHIFT -> END -> IDLE.
REQ-004 In IDLE, a clock edge with SCOM=1 SHALL move to START and latch TxBuffer, DATA_LEN, CS_i, CPOL and CPHA; with SCOM=0 the FSM stays in IDLE.
REQ-005 SCOM SHALL be ignored in every non-IDLE state, so a transfer is never restarted or aborted by SCOM.
REQ-006 START SHALL last 1 cycle, clear the receive shift register, and present bit 7 of TxBuffer[NBYTES-1] on COPI.
REQ-007 SHIFT SHALL last exactly 8*(DATA_LEN+1) cycles at one bit per clk:
- bits go out MSB-first, bytes in the order TxBuffer[NBYTES-1], TxBuffer[NBYTES-2], and so on;
- COPI changes only on rising clk edges.
REQ-008 Each rising clk edge in SHIFT SHALL shift the current CIPO value into bit 0 of the NBYTES*8-bit receive register; older bits move toward RxBuffer[NBYTES-1].
REQ-009 END SHALL last 1 cycle, copy the receive register to RxBuffer, and return to IDLE.
- For an N-byte transfer, byte k received (0-based) lands in RxBuffer[N-1-k].
- Bytes above N-1 read 0.
REQ-010 RxBuffer SHALL hold its value until the next END or reset.
REQ-011 PCLK SHALL be combinational and equal CPOL when not in SHIFT; in IDLE it follows the live CPOL input.
REQ-012 In SHIFT, PCLK SHALL equal CPOL^(~clk) when CPHA=0 and CPOL^clk when CPHA=1.
- This yields exactly 8*(DATA_LEN+1) PCLK pulses.
- CPHA=0: the leading edge falls mid-bit.
- CPHA=1: the leading edge coincides with the COPI update.
REQ-013 BUSY SHALL be 1 in START, SHIFT and END, and 0 in IDLE.
REQ-014 CS_gpio SHALL drive the latched CS_i in START, SHIFT and END, and all ones in IDLE.
REQ-015 COPI SHALL be 0 in IDLE.
REQ-016 SCOM=1 held continuously SHALL start a new transfer on the first IDLE cycle after END.

Reset
REQ-017 rst_n=1 at a rising clk edge SHALL force, from any state including mid-transfer:
- state IDLE;
- BUSY=0, STARTING=0, COPI=0;
- CS_gpio all ones;
- RxBuffer and the receive register all zeros.
REQ-018 PCLK SHALL equal CPOL while in reset.

Configuration
REQ-019 When macro SPI_CONTROLLER_LOOPBACK_EN is defined, the receive register SHALL sample the internal COPI instead of CIPO, and CIPO SHALL be ignored.
REQ-020 Without SPI_CONTROLLER_LOOPBACK_EN, CIPO SHALL be sampled as in REQ-008.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Idle, CPOL=0 then CPOL=1 -> PCLK=0 then PCLK=1 within 1 ns; BUSY=0; CS_gpio=0xFF.
- Mode 0, DATA_LEN=0, TxBuffer[3]=0xA5, CS_i=0x12, CIPO tied to COPI -> COPI sequence 1,0,1,0,0,1,0,1; CS_gpio=0x12 while BUSY; BUSY high for 10 cycles; RxBuffer[0]=0xA5, RxBuffer[3:1]=0.
- Mode 1, DATA_LEN=1, TxBuffer[3:2]=0xBEEF, loopback -> RxBuffer[1]=0xBE, RxBuffer[0]=0xEF; 16 PCLK pulses.
- Mode 3, DATA_LEN=3, TxBuffer=0xDEADCE11, loopback -> RxBuffer=0xDEADCE11; BUSY falls 34 cycles after the SCOM edge; STARTING high for exactly 1 cycle.
- Mode 2, DATA_LEN=2, TxBuffer[3:1]=0x123456 -> RxBuffer[2:0]=0x123456; SCOM pulses during SHIFT are ignored.
- rst_n asserted mid-SHIFT -> next cycle BUSY=0, CS_gpio=0xFF, RxBuffer=0, PCLK=CPOL.

Source files
------------

// File: rtl/spi_controller.sv
// spi_controller: SPI master shifting up to NBYTES bytes at one bit per clk; define SPI_CONTROLLER_LOOPBACK_EN to feed COPI back into the receive register
module spi_controller #(
  parameter int NBYTES = 4,
  parameter int NCS = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   SCOM,
  input  logic                   CPOL,
  input  logic                   CPHA,
  input  logic [1:0]             DATA_LEN,
  input  logic [NCS-1:0]         CS_i,
  input  logic [NBYTES-1:0][7:0] TxBuffer,
  input  logic                   CIPO,
  output logic                   COPI,
  output logic                   PCLK,
  output logic                   BUSY,
  output logic                   STARTING,
  output logic [NCS-1:0]         CS_gpio,
  output logic [NBYTES-1:0][7:0] RxBuffer
);
  localparam int W = NBYTES * 8;
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, START, SHIFT, S_END} state_t;
  state_t         state_q, state_d;
  logic [W-1:0]   tx_q, tx_d, rx_q, rx_d, rxbuf_q, rxbuf_d;
  logic [1:0]     len_q, len_d;
  logic [NCS-1:0] cs_q, cs_d;
  logic           cpol_q, cpol_d, cpha_q, cpha_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           last, rx_in;
  assign last = cnt_q == CW'({len_q, 3'b111});
`ifdef SPI_CONTROLLER_LOOPBACK_EN
  assign rx_in = COPI;
`else
  assign rx_in = CIPO;
`endif
  // state and datapath registers, cleared by reset from any state
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      rxbuf_q <= '0;
      len_q   <= '0;
      cs_q    <= '1;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rxbuf_q <= rxbuf_d;
      len_q   <= len_d;
      cs_q    <= cs_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      cnt_q   <= cnt_d;
    end
  end
  // next state: SCOM only matters in IDLE, SHIFT ends after the last bit
  always_comb begin
    state_d = state_q == IDLE  ? (SCOM ? START : IDLE) :
              state_q == START ? SHIFT :
              state_q == SHIFT ? (last ? S_END : SHIFT) : IDLE;
  end
  // latch the command on start, shift both registers during SHIFT, publish in END
  always_comb begin
    tx_d    = tx_q;
    rx_d    = rx_q;
    rxbuf_d = rxbuf_q;
    len_d   = len_q;
    cs_d    = cs_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE && SCOM) begin
      tx_d   = TxBuffer;
      len_d  = DATA_LEN;
      cs_d   = CS_i;
      cpol_d = CPOL;
      cpha_d = CPHA;
    end
    if (state_q == START) begin
      rx_d  = '0;
      cnt_d = '0;
    end
    if (state_q == SHIFT) begin
      tx_d  = {tx_q[W-2:0], 1'b0};
      rx_d  = {rx_q[W-2:0], rx_in};
      cnt_d = cnt_q + 1'b1;
    end
    if (state_q == S_END) rxbuf_d = rx_q;
  end
  // outputs; PCLK is gated from clk only while shifting and out of reset
  always_comb begin
    BUSY     = state_q != IDLE;
    STARTING = state_q == START;
    CS_gpio  = state_q == IDLE ? '1 : cs_q;
    COPI     = (state_q == START || state_q == SHIFT) ? tx_q[W-1] : 1'b0;
    PCLK     = (state_q == SHIFT && !rst_n) ? (cpol_q ^ clk ^ ~cpha_q) :
               (state_q == IDLE || rst_n) ? CPOL : cpol_q;
    RxBuffer = rxbuf_q;
  end
endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: directed scenarios with a receive-data scoreboard
module tb_spi_controller;
  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            SCOM = 1'b0, CPOL = 1'b0, CPHA = 1'b0;
  logic [1:0]      DATA_LEN = 2'd0;
  logic [7:0]      CS_i = 8'h00;
  logic [3:0][7:0] TxBuffer = '0;
  logic            CIPO, COPI, PCLK, BUSY, STARTING;
  logic [7:0]      CS_gpio;
  logic [3:0][7:0] RxBuffer;
  int              checks = 0, failures = 0, pulses = 0;
  logic            pclk_prev = 1'b0;
  logic [31:0]     exp_q[$];

  spi_controller #(.NBYTES(4), .NCS(8)) dut (
    .clk(clk), .rst_n(rst_n), .SCOM(SCOM), .CPOL(CPOL), .CPHA(CPHA),
    .DATA_LEN(DATA_LEN), .CS_i(CS_i), .TxBuffer(TxBuffer), .CIPO(CIPO),
    .COPI(COPI), .PCLK(PCLK), .BUSY(BUSY), .STARTING(STARTING),
    .CS_gpio(CS_gpio), .RxBuffer(RxBuffer)
  );

  assign CIPO = COPI;
  always #5 clk = ~clk;

  // sample PCLK in the middle of each clk half and count rising transitions
  always @(posedge clk or negedge clk) begin
    #2;
    if (PCLK && !pclk_prev) pulses++;
    pclk_prev = PCLK;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic pol, input logic pha, input logic [1:0] len,
                        input logic [7:0] cs, input logic [31:0] tx, input logic keep);
    CPOL = pol; CPHA = pha; DATA_LEN = len; CS_i = cs; TxBuffer = tx; SCOM = 1'b1;
    exp_q.push_back(tx >> (8 * (3 - int'(len))));
    tick();
    SCOM = keep;
  endtask

  task automatic xfer(input string tag, input logic [1:0] len, input logic [7:0] cs,
                      input logic [31:0] tx, input bit inject);
    int n = 0, st = 0, nb;
    logic [31:0] bits = '0;
    bit cs_ok = 1'b1;
    nb = 8 * (int'(len) + 1);
    pulses = 0;
    while (BUSY === 1'b1 && n < 100) begin
      if (STARTING) st++;
      if (CS_gpio !== cs) cs_ok = 1'b0;
      if (n >= 1 && n <= nb) bits = {bits[30:0], COPI};
      if (inject) SCOM = (n == 4 || n == 5);
      n++;
      tick();
    end
    chk({tag, "_busy_cycles"}, 64'(n), 64'(nb + 2));
    chk({tag, "_starting"}, 64'(st), 64'd1);
    chk({tag, "_cs"}, 64'(cs_ok), 64'd1);
    chk({tag, "_copi"}, 64'(bits), 64'(tx >> (32 - nb)));
    chk({tag, "_pulses"}, 64'(pulses), 64'(nb));
    chk({tag, "_sb_nonempty"}, 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) chk({tag, "_rx"}, 64'(RxBuffer), 64'(exp_q.pop_front()));
  endtask

  initial begin
    tick();
    tick();
    chk("reset_busy", 64'(BUSY), 64'd0);
    chk("reset_starting", 64'(STARTING), 64'd0);
    chk("reset_copi", 64'(COPI), 64'd0);
    chk("reset_cs", 64'(CS_gpio), 64'hFF);
    chk("reset_rx", 64'(RxBuffer), 64'd0);
    rst_n = 1'b0;
    tick();
    CPOL = 1'b0;
    #1;
    chk("idle_pclk_pol0", 64'(PCLK), 64'd0);
    CPOL = 1'b1;
    #1;
    chk("idle_pclk_pol1", 64'(PCLK), 64'd1);
    chk("idle_busy", 64'(BUSY), 64'd0);
    chk("idle_cs", 64'(CS_gpio), 64'hFF);
    tick();
    launch(1'b0, 1'b0, 2'd0, 8'h12, 32'hA53C7701, 1'b0);
    chk("m0_start_copi", 64'(COPI), 64'd1);
    xfer("mode0", 2'd0, 8'h12, 32'hA53C7701, 1'b0);
    launch(1'b0, 1'b1, 2'd1, 8'h01, 32'hBEEF1234, 1'b0);
    xfer("mode1", 2'd1, 8'h01, 32'hBEEF1234, 1'b0);
    launch(1'b1, 1'b1, 2'd3, 8'h80, 32'hDEADCE11, 1'b0);
    xfer("mode3", 2'd3, 8'h80, 32'hDEADCE11, 1'b0);
    launch(1'b1, 1'b0, 2'd2, 8'h0F, 32'h1234569A, 1'b0);
    xfer("mode2_scom_ignored", 2'd2, 8'h0F, 32'h1234569A, 1'b1);
    launch(1'b0, 1'b0, 2'd0, 8'h33, 32'h5A000000, 1'b1);
    xfer("hold_first", 2'd0, 8'h33, 32'h5A000000, 1'b0);
    exp_q.push_back(32'h0000005A);
    tick();
    chk("hold_restart", 64'(STARTING), 64'd1);
    SCOM = 1'b0;
    xfer("hold_second", 2'd0, 8'h33, 32'h5A000000, 1'b0);
    launch(1'b0, 1'b1, 2'd3, 8'h44, 32'hCAFEF00D, 1'b0);
    repeat (6) tick();
    rst_n = 1'b1;
    #1;
    chk("rst_pclk_during", 64'(PCLK), 64'(CPOL));
    tick();
    exp_q.delete();
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_cs", 64'(CS_gpio), 64'hFF);
    chk("rst_rx", 64'(RxBuffer), 64'd0);
    chk("rst_pclk", 64'(PCLK), 64'(CPOL));
    chk("rst_copi", 64'(COPI), 64'd0);
    rst_n = 1'b0;
    tick();
    chk("post_rst_idle", 64'(BUSY), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
